hazard_scheduler: RTL and testbench
===================================

HAZARD_SCHEDULER -- requirements
Module: hazard_scheduler

Interface
REQ-001 Parameter FORWARDING, default 0; 0 means no bypass paths (consumer waits for WB to complete), 1 means EX/MEM bypass present (only load-use stalls).
REQ-002 Parameter CNT_W, default 16; width of the bubble counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 id_valid  input  1  decoded instruction present in ID.
REQ-006 id_rs, id_rt  input  5 each  source register indices.
REQ-007 id_use_rs, id_use_rt  input  1 each  source actually read.
REQ-008 id_rd  input  5  destination index; 0 means no write.
REQ-009 id_is_load  input  1  instruction is lw/lh/lhu.
REQ-010 mem_busy  input  1  downstream freeze request; whole pipe holds.
REQ-011 issue  output  1  ID instruction advances into EX this cycle.
REQ-012 stall  output  1  hold PC and IF/ID register.
REQ-013 bubble  output  1  inject NOP (all-zero word) into EX.
REQ-014 freeze  output  1  hold all pipeline registers (mirror of mem_busy).
REQ-015 bubble_cnt  output  CNT_W  total bubbles injected since reset.
REQ-016 state_o  output  2  current FSM state encoding.

Function
REQ-017 Scoreboard SHALL hold three entries (EX, MEM, WB), each {valid, rd, is_load}; entries with rd=0 are stored invalid.
REQ-018 When not frozen, scoreboard SHALL shift every cycle: EX<-issued ID instruction or empty on bubble, MEM<-EX, WB<-MEM.
REQ-019 Hazard (FORWARDING=0): a used source equal to rd of any valid EX, MEM or WB entry, with source non-zero.
REQ-020 Hazard (FORWARDING=1): a used source equal to rd of a valid EX entry with is_load=1, with source non-zero.
REQ-021 issue = id_valid & ~hazard & ~mem_busy; stall = id_valid & hazard & ~mem_busy; bubble = stall; all combinational from current inputs and registered scoreboard.
REQ-022 mem_busy SHALL take priority over hazard: freeze=1, issue=stall=bubble=0, scoreboard and counter unchanged.
REQ-023 FSM states: IDLE (no id_valid), RUN (issuing), STALL (bubble injected), HOLD (mem_busy); next state registered from same-cycle conditions in priority HOLD > STALL > RUN > IDLE.
REQ-024 Dependency on latest producer only; distance-1 producer with FORWARDING=0 SHALL yield exactly 3 bubbles, distance-2 yields 2, distance-3 yields 1, distance-4 yields 0.
REQ-025 Load-use distance-1 with FORWARDING=1 SHALL yield exactly 1 bubble; non-load producers yield 0.
REQ-026 bubble_cnt SHALL increment by 1 per bubble cycle and saturate at all-ones.
REQ-027 id_valid=0 SHALL shift an empty entry into EX without counting a bubble.

Reset
REQ-028 On reset low, all scoreboard entries invalid, bubble_cnt=0, state IDLE, immediately and independent of clk.
REQ-029 Outputs during reset: issue=stall=bubble=freeze=0, state_o=IDLE.
REQ-030 Reset asserted mid-stall SHALL discard pending hazards; the first post-reset instruction issues without bubbles.

Structure
REQ-031 Shared package mips_pkg SHALL hold reg_idx_t (5 bits), sched_state_t enum {IDLE,RUN,STALL,HOLD}, and sb_entry_t struct.
REQ-032 Scoreboard shift register SHALL be a sub-module named hazard_scoreboard; comparison logic and FSM stay in the top.

Verification
REQ-033 FORWARDING=0: addi $10,$0,10 then add $11,$12,$10 back-to-back -> stall=1 for 3 cycles, bubble_cnt=3, add issues on 4th cycle.
REQ-034 FORWARDING=1: same sequence -> 0 bubbles; lw $16,0($10) then srl $20,$16,2 -> exactly 1 bubble, bubble_cnt=1.
REQ-035 Producer addi $0,$0,5 followed by consumer of $0 -> no stall in either mode.
REQ-036 mem_busy=1 for 2 cycles during a 3-bubble stall -> freeze=1, bubble_cnt frozen, total still 3 bubbles after release.
REQ-037 reset pulsed low during second bubble -> bubble_cnt=0, state IDLE, next dependent instruction issues with no stall.
REQ-038 bubble_cnt at all-ones plus one more hazard -> value stays all-ones.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types for the ID-stage hazard scheduler: register index, scheduler
// state encoding and the in-flight scoreboard entry.
package mips_pkg;

  localparam int unsigned REG_W = 5;

  typedef logic [REG_W-1:0] reg_idx_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    HOLD  = 2'd3
  } sched_state_t;

  typedef struct packed {
    logic     valid;
    reg_idx_t rd;
    logic     is_load;
  } sb_entry_t;

  // $0 is never a real destination, so such writers are tracked as empty slots
  function automatic sb_entry_t mk_entry(input logic v, input reg_idx_t rd, input logic ld);
    sb_entry_t e;
    e.valid   = v && (rd != '0);
    e.rd      = rd;
    e.is_load = ld;
    return e;
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Three-deep EX/MEM/WB record of in-flight destination registers; the whole
// shift holds while the pipe is frozen.
module hazard_scoreboard
  import mips_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      i_hold,
  input  sb_entry_t i_ex_in,
  output sb_entry_t o_ex,
  output sb_entry_t o_mem,
  output sb_entry_t o_wb
);

  sb_entry_t r_ex;
  sb_entry_t r_mem;
  sb_entry_t r_wb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex  <= '0;
      r_mem <= '0;
      r_wb  <= '0;
    end else if (!i_hold) begin
      r_ex  <= i_ex_in;
      r_mem <= r_ex;
      r_wb  <= r_mem;
    end
  end

  assign o_ex  = r_ex;
  assign o_mem = r_mem;
  assign o_wb  = r_wb;

endmodule

// File: rtl/hazard_scheduler.sv
// ID-stage RAW hazard detection and issue/stall/bubble control for a 5-stage
// pipe, with optional EX/MEM bypass (then only load-use hazards stall).
module hazard_scheduler
  import mips_pkg::*;
#(
  parameter int unsigned FORWARDING = 0,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [4:0]       id_rd,
  input  logic             id_is_load,
  input  logic             mem_busy,
  output logic             issue,
  output logic             stall,
  output logic             bubble,
  output logic             freeze,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [1:0]       state_o
);

  localparam bit FWD_EN = (FORWARDING != 0);

  sb_entry_t    w_ex;
  sb_entry_t    w_mem;
  sb_entry_t    w_wb;
  sb_entry_t    w_ex_in;
  logic         w_haz_all;
  logic         w_haz_ld;
  logic         w_hazard;
  sched_state_t r_state;
  sched_state_t w_state_nxt;
  logic [CNT_W-1:0] r_cnt;

  function automatic logic src_hit(input reg_idx_t src, input logic used,
                                   input sb_entry_t e, input logic need_load);
    return used && (src != '0) && e.valid && (e.rd == src) && (!need_load || e.is_load);
  endfunction

  hazard_scoreboard u_sb (
    .clk     (clk),
    .rst_n   (reset),
    .i_hold  (mem_busy),
    .i_ex_in (w_ex_in),
    .o_ex    (w_ex),
    .o_mem   (w_mem),
    .o_wb    (w_wb)
  );

  // Without bypass any in-flight writer blocks; with bypass only a load in EX
  always_comb begin
    w_haz_all = src_hit(id_rs, id_use_rs, w_ex,  1'b0) | src_hit(id_rt, id_use_rt, w_ex,  1'b0) |
                src_hit(id_rs, id_use_rs, w_mem, 1'b0) | src_hit(id_rt, id_use_rt, w_mem, 1'b0) |
                src_hit(id_rs, id_use_rs, w_wb,  1'b0) | src_hit(id_rt, id_use_rt, w_wb,  1'b0);
    w_haz_ld  = src_hit(id_rs, id_use_rs, w_ex, 1'b1) | src_hit(id_rt, id_use_rt, w_ex, 1'b1);
    w_hazard  = FWD_EN ? w_haz_ld : w_haz_all;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Control outputs are gated by reset so nothing advances while it is held
  always_comb begin
    issue       = 1'b0;
    stall       = 1'b0;
    bubble      = 1'b0;
    freeze      = 1'b0;
    w_state_nxt = IDLE;
    if (reset) begin
      freeze = mem_busy;
      issue  = id_valid & ~w_hazard & ~mem_busy;
      stall  = id_valid &  w_hazard & ~mem_busy;
      bubble = stall;
    end
    if (freeze)     w_state_nxt = HOLD;
    else if (stall) w_state_nxt = STALL;
    else if (issue) w_state_nxt = RUN;
  end

  assign w_ex_in = mk_entry(issue, id_rd, id_is_load);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                     r_cnt <= '0;
    else if (bubble && r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
  end

  assign bubble_cnt = r_cnt;
  assign state_o    = r_state;

endmodule

// File: tb/tb_hazard_scheduler.sv
// Bench for hazard_scheduler: one instance without bypass, one with bypass and
// a narrow bubble counter; expected cycle results are queued and compared.
module tb_hazard_scheduler;
  import mips_pkg::*;

  typedef struct packed {
    logic       v;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic [4:0] rd;
    logic       ld;
    logic       busy;
  } stim_t;

  typedef struct packed {
    logic         d;
    logic         issue;
    logic         stall;
    logic         freeze;
    sched_state_t st;
    logic [15:0]  cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  stim_t       s0;
  stim_t       s1;
  logic        iss0, stl0, bub0, frz0;
  logic        iss1, stl1, bub1, frz1;
  logic [15:0] cnt0;
  logic [2:0]  cnt1;
  logic [1:0]  st0, st1;

  int          n_vec  = 0;
  int          n_miss = 0;
  exp_t        q[$];
  string       tq[$];

  always #5 clk = ~clk;

  hazard_scheduler #(.FORWARDING(0), .CNT_W(16)) u_f0 (
    .clk(clk), .reset(reset), .id_valid(s0.v), .id_rs(s0.rs), .id_rt(s0.rt),
    .id_use_rs(s0.urs), .id_use_rt(s0.urt), .id_rd(s0.rd), .id_is_load(s0.ld),
    .mem_busy(s0.busy), .issue(iss0), .stall(stl0), .bubble(bub0), .freeze(frz0),
    .bubble_cnt(cnt0), .state_o(st0)
  );

  hazard_scheduler #(.FORWARDING(1), .CNT_W(3)) u_f1 (
    .clk(clk), .reset(reset), .id_valid(s1.v), .id_rs(s1.rs), .id_rt(s1.rt),
    .id_use_rs(s1.urs), .id_use_rt(s1.urt), .id_rd(s1.rd), .id_is_load(s1.ld),
    .mem_busy(s1.busy), .issue(iss1), .stall(stl1), .bubble(bub1), .freeze(frz1),
    .bubble_cnt(cnt1), .state_o(st1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic stim_t ins(input int rs, input int rt, input bit urs, input bit urt,
                                input int rd, input bit ld);
    stim_t s;
    s.v = 1'b1; s.rs = 5'(rs); s.rt = 5'(rt); s.urs = urs; s.urt = urt;
    s.rd = 5'(rd); s.ld = ld; s.busy = 1'b0;
    return s;
  endfunction

  // Drive one cycle on instance d (other idles) and queue what should be seen
  task automatic cyc(input int d, input stim_t s, input bit ei, input bit es, input bit ef,
                     input sched_state_t st, input int cnt, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (d == 0) begin s0 = s; s1 = '0; end
    else        begin s1 = s; s0 = '0; end
    e.d = 1'(d); e.issue = ei; e.stall = es; e.freeze = ef; e.st = st; e.cnt = 16'(cnt);
    q.push_back(e);
    tq.push_back(tag);
  endtask

  task automatic idle3(input int d, input int cnt, input string tag);
    cyc(d, '0, 0, 0, 0, RUN,  cnt, {tag, "_dr1"});
    cyc(d, '0, 0, 0, 0, IDLE, cnt, {tag, "_dr2"});
    cyc(d, '0, 0, 0, 0, IDLE, cnt, {tag, "_dr3"});
  endtask

  always @(negedge clk) begin : mon
    exp_t  e;
    string t;
    if (q.size() != 0) begin
      e = q.pop_front();
      t = tq.pop_front();
      if (!e.d) begin
        chk({t, ":issue"},  32'(iss0), 32'(e.issue));
        chk({t, ":stall"},  32'(stl0), 32'(e.stall));
        chk({t, ":bubble"}, 32'(bub0), 32'(e.stall));
        chk({t, ":freeze"}, 32'(frz0), 32'(e.freeze));
        chk({t, ":state"},  32'(st0),  32'(e.st));
        chk({t, ":cnt"},    32'(cnt0), 32'(e.cnt));
      end else begin
        chk({t, ":issue"},  32'(iss1), 32'(e.issue));
        chk({t, ":stall"},  32'(stl1), 32'(e.stall));
        chk({t, ":bubble"}, 32'(bub1), 32'(e.stall));
        chk({t, ":freeze"}, 32'(frz1), 32'(e.freeze));
        chk({t, ":state"},  32'(st1),  32'(e.st));
        chk({t, ":cnt"},    32'(cnt1), 32'(e.cnt));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    stim_t bv;
    stim_t add_s, c2, c3, cm, srl_s, use_s;
    reset = 1'b0;
    s0 = '0;
    s1 = '0;

    // outputs stay quiet in reset even with valid and busy asserted
    bv = ins(10, 11, 1, 1, 12, 1);
    bv.busy = 1'b1;
    cyc(0, bv, 0, 0, 0, IDLE, 0, "rst_f0");
    cyc(1, bv, 0, 0, 0, IDLE, 0, "rst_f1");
    @(negedge clk);
    #1 reset = 1'b1; s0 = '0; s1 = '0;

    // no bypass, distance-1: three bubbles then issue
    add_s = ins(12, 10, 1, 1, 11, 0);
    cyc(0, ins(0, 0, 1, 0, 10, 0), 1, 0, 0, IDLE, 0, "f0_addi");
    cyc(0, add_s, 0, 1, 0, RUN,   0, "f0_d1_b1");
    cyc(0, add_s, 0, 1, 0, STALL, 1, "f0_d1_b2");
    cyc(0, add_s, 0, 1, 0, STALL, 2, "f0_d1_b3");
    cyc(0, add_s, 1, 0, 0, STALL, 3, "f0_d1_iss");
    idle3(0, 3, "f0_d1");

    // distance-2: two bubbles
    c2 = ins(5, 0, 1, 0, 13, 0);
    cyc(0, ins(1, 0, 1, 0, 5, 0), 1, 0, 0, IDLE, 3, "f0_d2_p");
    cyc(0, ins(1, 0, 1, 0, 6, 0), 1, 0, 0, RUN,  3, "f0_d2_x");
    cyc(0, c2, 0, 1, 0, RUN,   3, "f0_d2_b1");
    cyc(0, c2, 0, 1, 0, STALL, 4, "f0_d2_b2");
    cyc(0, c2, 1, 0, 0, STALL, 5, "f0_d2_iss");
    idle3(0, 5, "f0_d2");

    // distance-3: one bubble; an unused matching source must not stall
    c3 = ins(0, 7, 0, 1, 14, 0);
    cyc(0, ins(0, 0, 0, 0, 7, 0), 1, 0, 0, IDLE, 5, "f0_d3_p");
    cyc(0, ins(0, 0, 0, 0, 8, 0), 1, 0, 0, RUN,  5, "f0_d3_x1");
    cyc(0, ins(7, 0, 0, 0, 9, 0), 1, 0, 0, RUN,  5, "f0_unused_src");
    cyc(0, c3, 0, 1, 0, RUN,   5, "f0_d3_b1");
    cyc(0, c3, 1, 0, 0, STALL, 6, "f0_d3_iss");
    idle3(0, 6, "f0_d3");

    // writes to $0 never create a dependency
    cyc(0, ins(0, 0, 1, 0, 0, 0),  1, 0, 0, IDLE, 6, "f0_r0_p");
    cyc(0, ins(0, 0, 1, 1, 15, 0), 1, 0, 0, RUN,  6, "f0_r0_c");
    idle3(0, 6, "f0_r0");

    // mem_busy for two cycles inside a 3-bubble stall
    cm = ins(12, 10, 1, 1, 11, 0);
    cyc(0, ins(0, 0, 1, 0, 10, 0), 1, 0, 0, IDLE, 6, "f0_mb_p");
    cyc(0, cm, 0, 1, 0, RUN, 6, "f0_mb_b1");
    cm.busy = 1'b1;
    cyc(0, cm, 0, 0, 1, STALL, 7, "f0_mb_hold1");
    cyc(0, cm, 0, 0, 1, HOLD,  7, "f0_mb_hold2");
    cm.busy = 1'b0;
    cyc(0, cm, 0, 1, 0, HOLD,  7, "f0_mb_b2");
    cyc(0, cm, 0, 1, 0, STALL, 8, "f0_mb_b3");
    cyc(0, cm, 1, 0, 0, STALL, 9, "f0_mb_iss");
    idle3(0, 9, "f0_mb");

    // reset during the second bubble discards the pending hazard
    cyc(0, ins(0, 0, 1, 0, 10, 0), 1, 0, 0, IDLE, 9, "f0_rs_p");
    cyc(0, cm, 0, 1, 0, RUN,   9,  "f0_rs_b1");
    cyc(0, cm, 0, 1, 0, STALL, 10, "f0_rs_b2");
    @(negedge clk);
    #1 reset = 1'b0; s0 = '0;
    #1;
    chk("f0_rs_async_state", 32'(st0),  32'(IDLE));
    chk("f0_rs_async_cnt",   32'(cnt0), 32'd0);
    chk("f0_rs_async_issue", 32'(iss0), 32'd0);
    #1 reset = 1'b1;
    cyc(0, '0, 0, 0, 0, IDLE, 0, "f0_rs_idle");
    cyc(0, ins(10, 0, 1, 0, 11, 0), 1, 0, 0, IDLE, 0, "f0_rs_iss");
    idle3(0, 0, "f0_rs");

    // with bypass: ALU producer back-to-back needs no bubble
    cyc(1, ins(0, 0, 1, 0, 10, 0),   1, 0, 0, IDLE, 0, "f1_addi");
    cyc(1, ins(12, 10, 1, 1, 11, 0), 1, 0, 0, RUN,  0, "f1_add");
    idle3(1, 0, "f1_alu");

    // load-use distance-1: exactly one bubble
    srl_s = ins(0, 16, 0, 1, 20, 0);
    cyc(1, ins(10, 0, 1, 0, 16, 1), 1, 0, 0, IDLE, 0, "f1_lw");
    cyc(1, srl_s, 0, 1, 0, RUN,   0, "f1_lu_b1");
    cyc(1, srl_s, 1, 0, 0, STALL, 1, "f1_lu_iss");
    idle3(1, 1, "f1_lu");

    // load-use distance-2: bypass covers it
    cyc(1, ins(10, 0, 1, 0, 16, 1), 1, 0, 0, IDLE, 1, "f1_lw2");
    cyc(1, ins(0, 0, 0, 0, 5, 0),   1, 0, 0, RUN,  1, "f1_lw2_x");
    cyc(1, ins(16, 0, 1, 0, 21, 0), 1, 0, 0, RUN,  1, "f1_lw2_use");
    idle3(1, 1, "f1_lw2");

    // load into $0 followed by a reader of $0
    cyc(1, ins(10, 0, 1, 0, 0, 1), 1, 0, 0, IDLE, 1, "f1_r0_lw");
    cyc(1, ins(0, 0, 1, 1, 22, 0), 1, 0, 0, RUN,  1, "f1_r0_use");
    idle3(1, 1, "f1_r0");

    // 3-bit counter must stick at 7
    use_s = ins(16, 16, 1, 1, 17, 0);
    for (int i = 0; i < 7; i++) begin
      int pre;
      int post;
      pre  = (1 + i > 7) ? 7 : 1 + i;
      post = (2 + i > 7) ? 7 : 2 + i;
      cyc(1, ins(1, 0, 1, 0, 16, 1), 1, 0, 0, (i == 0) ? IDLE : RUN, pre, "f1_sat_lw");
      cyc(1, use_s, 0, 1, 0, RUN,   pre,  "f1_sat_b");
      cyc(1, use_s, 1, 0, 0, STALL, post, "f1_sat_iss");
    end
    idle3(1, 7, "f1_sat");

    @(negedge clk);
    #1;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
